booth_multiplier: RTL and testbench
===================================

Name: booth_multiplier

Overview:
- Signed 16x16 to 32-bit pipelined multiplier; a datapath leaf used wherever a registered signed product is needed.
- Operands are captured on a clock edge where input_ready is high.
- The product appears a fixed number of cycles later, flagged by a one-cycle output_valid pulse.
- Implementation: radix-4 Booth partial products, carry-save reduction, final carry-propagate add; 3 register stages.

Parameters:
- WIDTH, 16, operand width; prod is 2*WIDTH. Only 16 is required to be verified.

Ports:
- clk  in  1  clock; all registers update on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- input_ready  in  1  operand-valid strobe, sampled on the rising edge of clk.
- a  in  16  signed two's-complement multiplicand.
- b  in  16  signed two's-complement multiplier.
- prod  out  32  signed product a*b, registered.
- output_valid  out  1  high for exactly one cycle when prod is updated with a new result.

Behaviour:
- Reset: while rst_n=0, all pipeline registers, prod and output_valid are 0, asynchronously. First capture occurs at the first rising edge after rst_n deasserts.
- Capture (stage 1): at rising edge E0 with input_ready=1, register a, b and a valid bit. With input_ready=0, the valid bit is cleared and operand registers may hold.
- Stage 2, edge E1:
  - Form 9 radix-4 Booth partial products (b sign-extended to 18 bits, digits -2..+2).
  - Each partial product is sign-extended with the standard sign-extension constant.
  - Reduce to sum/carry rows with carry-save adders; register both rows and the valid bit.
- Stage 3, edge E2:
  - prod <= sum + carry, truncated to 32 bits.
  - output_valid <= stage-2 valid.
- Latency: the result of the operands sampled at E0 is visible on prod just after E2, i.e. 2 cycles after the capture edge.
- output_valid is high from E2 to E3 only, unless another valid operation follows back-to-back.
- Throughput: one operation per cycle. input_ready may be high on consecutive edges, or every Nth edge; each accepted pair yields exactly one output_valid pulse, in order.
- prod holds its last result while output_valid=0. It does not return to 0 except on reset.
- Arithmetic: exact signed result for the full range. -32768*-32768 = 1073741824 fits in 32 bits; no saturation or overflow flag.
- Changes on a/b while input_ready=0 have no effect on prod.
- Reset mid-operation: all in-flight operations are discarded. No output_valid pulse follows for operands captured before reset.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package mult_pkg:
  - WIDTH = 16 and PROD_WIDTH = 32 constants.
  - Booth digit enum: ZERO, POS1, POS2, NEG1, NEG2.
- One sub-module booth_pp_gen:
  - Inputs: one 3-bit Booth window and the multiplicand.
  - Output: the encoded, sign-handled partial product.
  - Instantiated 9 times.
- Carry-save reduction and the final adder stay in the top module.

Test Plan:
- Reset: rst_n=0 mid-stream with ops in flight -> prod=0, output_valid=0 immediately; no output_valid pulse for those ops after release.
- Ops every 2 cycles (input_ready high on every other edge):
  - 3*21845 -> 65535
  - -21846*-32767 -> 715827882
  - 21845*-16384 -> -357908480
  - 32767*32513 -> 1065353471
  - Each result appears 2 cycles after its capture edge, with a single output_valid pulse.
- Sign/boundary cases:
  - -1*32513 -> -32513
  - -1*-255 -> 255
  - -16385*-1 -> 16385
  - 32767*-1 -> -32767
  - 0*5 -> 0
  - -1*-1 -> 1
- Extremes:
  - 32767*32767 -> 1073676289
  - -32767*-32767 -> 1073676289
  - -32768*-32768 -> 1073741824
  - -32768*32767 -> -1073709056
- Back-to-back: input_ready high 4 consecutive edges with distinct pairs -> 4 consecutive output_valid cycles, correct in-order products.
- Idle: toggle a/b with input_ready=0 -> prod unchanged, output_valid stays 0.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared constants, Booth digit encoding and sign-extension constant for the signed multiplier.
// Pure declarations: no latency, no flow control.
package mult_pkg;

    localparam int WIDTH      = 16;
    localparam int PROD_WIDTH = 2 * WIDTH;

    typedef enum logic [2:0] {
        ZERO,
        POS1,
        POS2,
        NEG1,
        NEG2
    } booth_digit_e;

    // Radix-4 window {b[2i+1], b[2i], b[2i-1]} -> digit in -2..+2
    function automatic booth_digit_e booth_decode(input logic [2:0] win);
        booth_digit_e digit;
        case (win)
            3'b001, 3'b010: digit = POS1;
            3'b011:         digit = POS2;
            3'b100:         digit = NEG2;
            3'b101, 3'b110: digit = NEG1;
            default:        digit = ZERO;
        endcase
        return digit;
    endfunction

    // Each partial product carries its sign as an inverted MSB at bit w+1;
    // this constant subtracts the 2^(w+1) bias of every row in one go.
    function automatic logic [63:0] sext_const(input int w);
        logic [63:0] k;
        k = '0;
        for (int i = 0; i < w / 2 + 1; i++) begin
            k = k - (64'd1 << (w + 1 + 2 * i));
        end
        return k;
    endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// One radix-4 Booth partial product: digit*mcand with the sign bit inverted for constant-based extension.
// Combinational, no latency, no flow control.
module booth_pp_gen
    import mult_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic [2:0]   win,
    input  logic [W-1:0] mcand,
    output logic [W+1:0] pp
);

    booth_digit_e digit;
    logic [W+1:0] m1;
    logic [W+1:0] m2;
    logic [W+1:0] val;

    assign digit = booth_decode(win);
    assign m1    = {{2{mcand[W-1]}}, mcand};
    assign m2    = {mcand[W-1], mcand, 1'b0};

    always_comb begin
        val = '0;
        case (digit)
            POS1:    val = m1;
            POS2:    val = m2;
            NEG1:    val = -m1;
            NEG2:    val = -m2;
            default: val = '0;
        endcase
    end

    assign pp = {~val[W+1], val[W:0]};

endmodule

// File: rtl/booth_multiplier.sv
// Signed WIDTH x WIDTH pipelined Booth multiplier (capture, CSA reduce, final add).
// Latency 2 cycles from capture edge to prod/output_valid; one op per cycle, never stalls.
module booth_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = mult_pkg::WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 input_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   prod,
    output logic                 output_valid
);

    localparam int PW       = 2 * WIDTH;
    localparam int NUM_PP   = WIDTH / 2 + 1;
    localparam int NUM_ROWS = NUM_PP + 1;
    localparam int NUM_CSA  = NUM_ROWS - 2;
    localparam logic [PW-1:0] SEXT_K = PW'(sext_const(WIDTH));

    // Stage 1: operand capture
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             vld_s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            vld_s1 <= 1'b0;
        end else begin
            vld_s1 <= input_ready;
            if (input_ready) begin
                a_q <= a;
                b_q <= b;
            end
        end
    end

    // Multiplier extended to WIDTH+2 bits plus the implicit zero below bit 0
    logic [WIDTH+2:0] bx;
    logic [WIDTH+1:0] pp   [NUM_PP];
    logic [PW-1:0]    rows [NUM_ROWS];

    assign bx = {b_q[WIDTH-1], b_q[WIDTH-1], b_q, 1'b0};

    for (genvar i = 0; i < NUM_PP; i++) begin : g_pp
        booth_pp_gen #(
            .W(WIDTH)
        ) u_pp (
            .win  (bx[2*i+2:2*i]),
            .mcand(a_q),
            .pp   (pp[i])
        );
        assign rows[i] = PW'(pp[i]) << (2 * i);
    end

    assign rows[NUM_PP] = SEXT_K;

    // Linear 3:2 compressor chain folding all rows into one sum/carry pair
    logic [PW-1:0] sum_ch [NUM_CSA];
    logic [PW-1:0] car_ch [NUM_CSA];

    assign sum_ch[0] = rows[0] ^ rows[1] ^ rows[2];
    assign car_ch[0] = ((rows[0] & rows[1]) | (rows[0] & rows[2]) | (rows[1] & rows[2])) << 1;

    for (genvar j = 1; j < NUM_CSA; j++) begin : g_csa
        assign sum_ch[j] = sum_ch[j-1] ^ car_ch[j-1] ^ rows[j+2];
        assign car_ch[j] = ((sum_ch[j-1] & car_ch[j-1]) |
                            (sum_ch[j-1] & rows[j+2])   |
                            (car_ch[j-1] & rows[j+2])) << 1;
    end

    // Stage 2: redundant sum/carry
    logic [PW-1:0] sum_q;
    logic [PW-1:0] car_q;
    logic          vld_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            car_q  <= '0;
            vld_s2 <= 1'b0;
        end else begin
            sum_q  <= sum_ch[NUM_CSA-1];
            car_q  <= car_ch[NUM_CSA-1];
            vld_s2 <= vld_s1;
        end
    end

    // Stage 3: carry-propagate add; prod holds between results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod         <= '0;
            output_valid <= 1'b0;
        end else begin
            output_valid <= vld_s2;
            if (vld_s2) begin
                prod <= sum_q + car_q;
            end
        end
    end

endmodule

// File: tb/tb_booth_multiplier.sv
// Directed self-checking bench for booth_multiplier.
module tb_booth_multiplier;

    logic               clk;
    logic               rst_n;
    logic               input_ready;
    logic signed [15:0] a;
    logic signed [15:0] b;
    logic signed [31:0] prod;
    logic               output_valid;

    int checks;
    int errors;
    logic signed [31:0] last_prod;

    booth_multiplier #(.WIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .input_ready (input_ready),
        .a           (a),
        .b           (b),
        .prod        (prod),
        .output_valid(output_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        input_ready = 1'b0;
        a = '0;
        b = '0;
        #2;
        checks++;
        if (prod !== 32'sd0) begin
            errors++;
            $display("FAIL reset_prod: got %0d want 0", prod);
        end
        checks++;
        if (output_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b want 0", output_valid);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (output_valid !== 1'b0 || prod !== 32'sd0) begin
            errors++;
            $display("FAIL reset_release: valid %b prod %0d want 0/0", output_valid, prod);
        end
        last_prod = 32'sd0;
    endtask

    task automatic test_every_other();
        logic signed [15:0] av [4] = '{16'sd3, -16'sd21846, 16'sd21845, 16'sd32767};
        logic signed [15:0] bv [4] = '{16'sd21845, -16'sd32767, -16'sd16384, 16'sd32513};
        logic signed [31:0] ev [4] = '{32'sd65535, 32'sd715827882, -32'sd357908480, 32'sd1065353471};
        a = av[0];
        b = bv[0];
        input_ready = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            input_ready = 1'b0;
            a = 16'($urandom);
            b = 16'($urandom);
            tick();
            checks++;
            if (output_valid !== 1'b0 || prod !== last_prod) begin
                errors++;
                $display("FAIL eo_gap%0d: valid %b prod %0d want 0/%0d", k, output_valid, prod, last_prod);
            end
            if (k < 3) begin
                a = av[k+1];
                b = bv[k+1];
                input_ready = 1'b1;
            end
            tick();
            checks++;
            if (output_valid !== 1'b1 || prod !== ev[k]) begin
                errors++;
                $display("FAIL eo_res%0d: valid %b prod %0d want 1/%0d", k, output_valid, prod, ev[k]);
            end
            last_prod = ev[k];
        end
        input_ready = 1'b0;
        tick();
        checks++;
        if (output_valid !== 1'b0) begin
            errors++;
            $display("FAIL eo_pulse_end: got %b want 0", output_valid);
        end
    endtask

    task automatic test_sign_boundary();
        logic signed [15:0] av [10] = '{-16'sd1, -16'sd1, -16'sd16385, 16'sd32767, 16'sd0, -16'sd1,
                                        16'sd32767, -16'sd32767, -16'sd32768, -16'sd32768};
        logic signed [15:0] bv [10] = '{16'sd32513, -16'sd255, -16'sd1, -16'sd1, 16'sd5, -16'sd1,
                                        16'sd32767, -16'sd32767, -16'sd32768, 16'sd32767};
        logic signed [31:0] ev [10] = '{-32'sd32513, 32'sd255, 32'sd16385, -32'sd32767, 32'sd0, 32'sd1,
                                        32'sd1073676289, 32'sd1073676289, 32'sd1073741824, -32'sd1073709056};
        for (int k = 0; k < 10; k++) begin
            a = av[k];
            b = bv[k];
            input_ready = 1'b1;
            tick();
            input_ready = 1'b0;
            a = 16'($urandom);
            b = 16'($urandom);
            tick();
            checks++;
            if (output_valid !== 1'b0 || prod !== last_prod) begin
                errors++;
                $display("FAIL sb_wait%0d: valid %b prod %0d want 0/%0d", k, output_valid, prod, last_prod);
            end
            tick();
            checks++;
            if (output_valid !== 1'b1 || prod !== ev[k]) begin
                errors++;
                $display("FAIL sb_res%0d: valid %b prod %0d want 1/%0d", k, output_valid, prod, ev[k]);
            end
            last_prod = ev[k];
        end
        tick();
        checks++;
        if (output_valid !== 1'b0 || prod !== last_prod) begin
            errors++;
            $display("FAIL sb_hold: valid %b prod %0d want 0/%0d", output_valid, prod, last_prod);
        end
    endtask

    task automatic test_back_to_back();
        logic signed [15:0] av [4] = '{16'sd100, -16'sd300, 16'sd12345, -16'sd1000};
        logic signed [15:0] bv [4] = '{16'sd200, 16'sd7, -16'sd2, -16'sd1000};
        logic signed [31:0] ev [4] = '{32'sd20000, -32'sd2100, -32'sd24690, 32'sd1000000};
        for (int k = 0; k < 6; k++) begin
            if (k < 4) begin
                a = av[k];
                b = bv[k];
                input_ready = 1'b1;
            end else begin
                input_ready = 1'b0;
                a = 16'($urandom);
                b = 16'($urandom);
            end
            tick();
            if (k >= 2) begin
                checks++;
                if (output_valid !== 1'b1 || prod !== ev[k-2]) begin
                    errors++;
                    $display("FAIL b2b_res%0d: valid %b prod %0d want 1/%0d", k - 2, output_valid, prod, ev[k-2]);
                end
            end
        end
        last_prod = ev[3];
        tick();
        checks++;
        if (output_valid !== 1'b0 || prod !== last_prod) begin
            errors++;
            $display("FAIL b2b_end: valid %b prod %0d want 0/%0d", output_valid, prod, last_prod);
        end
    endtask

    task automatic test_idle();
        input_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            tick();
            checks++;
            if (output_valid !== 1'b0 || prod !== last_prod) begin
                errors++;
                $display("FAIL idle%0d: valid %b prod %0d want 0/%0d", k, output_valid, prod, last_prod);
            end
        end
    endtask

    task automatic test_reset_midstream();
        input_ready = 1'b1;
        a = 16'sd5;  b = 16'sd6;  tick();
        a = 16'sd7;  b = 16'sd8;  tick();
        a = 16'sd9;  b = 16'sd10; tick();
        checks++;
        if (output_valid !== 1'b1 || prod !== 32'sd30) begin
            errors++;
            $display("FAIL mid_pre: valid %b prod %0d want 1/30", output_valid, prod);
        end
        input_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (output_valid !== 1'b0 || prod !== 32'sd0) begin
            errors++;
            $display("FAIL mid_async: valid %b prod %0d want 0/0", output_valid, prod);
        end
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (output_valid !== 1'b0 || prod !== 32'sd0) begin
                errors++;
                $display("FAIL mid_after%0d: valid %b prod %0d want 0/0", k, output_valid, prod);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_every_other();
        test_sign_boundary();
        test_back_to_back();
        test_idle();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
